// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-level types and constants
// Contents: state encodings, colour constants, screen size, layer-select helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Upper layer wins wherever it is not fully black.
  function automatic logic [11:0] first_nonzero(input logic [11:0] upper,
                                                input logic [11:0] lower);
    return (upper != BLACK) ? upper : lower;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// rtl/game_state_ctrl_if.sv - video/game signal bundle for game_state_ctrl
// master: drives dtg position, button, collision flag and layer pixels;
//         receives pixel_out, game_state, freeze, score.
// slave : the controller side.
// HIGH_SCORE_EN adds high_score [SCORE_W] (slave output).
interface game_state_ctrl_if #(
  parameter int SCORE_W = 16
);
  logic [9:0]         pix_row;
  logic [9:0]         pix_col;
  logic               video_on;
  logic               start_btn;
  logic               collision_flag;
  logic [11:0]        game_over_in;
  logic [11:0]        background_in;
  logic [11:0]        moving_cars_in;
  logic [11:0]        player_car_in;
  logic [11:0]        pixel_out;
  logic [1:0]         game_state;
  logic               freeze;
  logic [SCORE_W-1:0] score;
`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score;
`endif

  modport master (
`ifdef HIGH_SCORE_EN
    input  high_score,
`endif
    output pix_row, pix_col, video_on, start_btn, collision_flag,
    output game_over_in, background_in, moving_cars_in, player_car_in,
    input  pixel_out, game_state, freeze, score
  );

  modport slave (
`ifdef HIGH_SCORE_EN
    output high_score,
`endif
    input  pix_row, pix_col, video_on, start_btn, collision_flag,
    input  game_over_in, background_in, moving_cars_in, player_car_in,
    output pixel_out, game_state, freeze, score
  );

endinterface

// File: rtl/game_state_ctrl_btn_sync_edge.sv
// rtl/game_state_ctrl_btn_sync_edge.sv - 2-flop synchroniser plus rising-edge pulse
// Ports: clk, reset (sync, active-high), i_btn (async raw button),
//        o_pulse (one-cycle pulse on synchronised rising edge).
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game FSM, score, freeze and final pixel mux
// Ports: clk, reset (sync, active-high), bus (game_state_ctrl_if.slave):
//   in : pix_row, pix_col, video_on, start_btn, collision_flag, layer pixels
//   out: pixel_out (1-cycle registered), game_state, freeze, score
// Macro HIGH_SCORE_EN: adds registered high_score, loaded on OVER entry.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int COLL_THRESH  = 4,
  parameter int CRASH_FRAMES = 60,
  parameter int SCORE_DIV    = 30,
  parameter int SCORE_W      = 16
) (
  input logic               clk,
  input logic               reset,
  game_state_ctrl_if.slave  bus
);

  localparam int FC_W = (SCORE_DIV > 2) ? $clog2(SCORE_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(SCORE_DIV - 1);
  localparam logic [7:0]      CF_LAST  = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0]      C_THRESH = 8'(COLL_THRESH);

  game_state_t        r_state;
  logic [9:0]         r_prev_row;
  logic [9:0]         r_prev_col;
  logic [7:0]         r_coll_cnt;
  logic [7:0]         r_crash_cnt;
  logic [FC_W-1:0]    r_frame_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [11:0]        r_pixel;
  logic               r_freeze;
`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_high_score;
`endif

  logic        w_tick;
  logic        w_start;
  logic        w_coll_hit;
  logic [11:0] w_cars_pix;
  logic [11:0] w_play_pix;
  logic [11:0] w_crash_pix;

  btn_sync_edge u_start (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (bus.start_btn),
    .o_pulse (w_start)
  );

  // Tick only on arrival at the origin, so a held (0,0) yields one pulse.
  assign w_tick = (bus.pix_row == 10'd0) && (bus.pix_col == 10'd0) &&
                  ((r_prev_row != 10'd0) || (r_prev_col != 10'd0));

  assign w_coll_hit  = (r_coll_cnt >= C_THRESH);
  assign w_cars_pix  = first_nonzero(bus.moving_cars_in, bus.background_in);
  assign w_play_pix  = first_nonzero(bus.player_car_in, w_cars_pix);
  // Player car blinks off for 8 of every 16 crash frames.
  assign w_crash_pix = r_crash_cnt[3] ? w_cars_pix : w_play_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev_row  <= '0;
      r_prev_col  <= '0;
      r_coll_cnt  <= '0;
      r_crash_cnt <= '0;
      r_frame_cnt <= '0;
      r_score     <= '0;
      r_pixel     <= BLACK;
      r_freeze    <= 1'b1;
`ifdef HIGH_SCORE_EN
      r_high_score <= '0;
`endif
    end else begin
      r_prev_row <= bus.pix_row;
      r_prev_col <= bus.pix_col;
      r_freeze   <= (r_state != ST_PLAY);

      if (!bus.video_on) begin
        r_pixel <= BLACK;
      end else begin
        case (r_state)
          ST_IDLE:  r_pixel <= bus.background_in;
          ST_PLAY:  r_pixel <= w_play_pix;
          ST_CRASH: r_pixel <= w_crash_pix;
          default:  r_pixel <= first_nonzero(bus.game_over_in, bus.background_in);
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_PLAY;
            r_score     <= '0;
            r_frame_cnt <= '0;
            r_coll_cnt  <= '0;
          end
        end

        ST_PLAY: begin
          if (w_tick) begin
            if (r_frame_cnt == FC_LAST) begin
              r_frame_cnt <= '0;
              if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
          // Crash takes priority over a same-cycle tick; both clear the count.
          if (w_coll_hit) begin
            r_state     <= ST_CRASH;
            r_crash_cnt <= '0;
            r_coll_cnt  <= '0;
          end else if (w_tick) begin
            r_coll_cnt <= '0;
          end else if (bus.collision_flag && (r_coll_cnt != 8'hFF)) begin
            r_coll_cnt <= r_coll_cnt + 1'b1;
          end
        end

        ST_CRASH: begin
          if (w_tick) begin
            r_crash_cnt <= r_crash_cnt + 1'b1;
            if (r_crash_cnt == CF_LAST) begin
              r_state <= ST_OVER;
`ifdef HIGH_SCORE_EN
              if (r_score > r_high_score) r_high_score <= r_score;
`endif
            end
          end
        end

        default: begin
          if (w_start) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pixel_out  = r_pixel;
  assign bus.game_state = r_state;
  assign bus.freeze     = r_freeze;
  assign bus.score      = r_score;
`ifdef HIGH_SCORE_EN
  assign bus.high_score = r_high_score;
`endif

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Downstream consumer of the collision flag and game-over image produced by the game-over overlay stage.
- Owns the game-level FSM (IDLE, PLAY, CRASH, OVER), frame-based score counter and start-button handling.
- Drives the final 12-bit pixel onto the VGA colour path.
- Provides a freeze signal that halts the moving-car and player-car stages.

Parameters:
- COLL_THRESH, 4: collision-flag pixels needed in one frame to declare a crash.
- CRASH_FRAMES, 60: frames spent in CRASH before OVER.
- SCORE_DIV, 30: PLAY frames per score increment.
- SCORE_W, 16: score width.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- pix_row  in  10  current row from dtg
- pix_col  in  10  current column from dtg
- video_on  in  1  dtg visible-area flag
- start_btn  in  1  raw pushbutton, asynchronous
- collision_flag  in  1  per-pixel collision indication
- game_over_in  in  12  game-over image pixel
- background_in  in  12  road/background pixel
- moving_cars_in  in  12  moving-cars pixel
- player_car_in  in  12  player-car pixel
- pixel_out  out  12  final colour to VGA
- game_state  out  2  0=IDLE, 1=PLAY, 2=CRASH, 3=OVER
- freeze  out  1  1 = car stages hold position
- score  out  SCORE_W  current score

Behaviour:
- Reset values:
  - game_state=IDLE, freeze=1, score=0, pixel_out=0.
  - All counters and synchroniser flops 0.
- Frame tick:
  - One-cycle pulse when (pix_row,pix_col) becomes (0,0).
  - Detected as a change versus the previous registered position, so holding (0,0) for several clocks gives one pulse only.
- start_btn:
  - Passes through a 2-flop synchroniser, then rising-edge detection.
  - Gives start_pulse, one cycle wide.
- coll_cnt (sat. 8 bits):
  - Increments on each cycle with collision_flag=1 while in PLAY.
  - Cleared on every frame tick.
  - Cleared on leaving PLAY.
- FSM, all transitions registered:
  - IDLE -> PLAY on start_pulse. Score clears to 0.
  - PLAY -> CRASH in the cycle after coll_cnt reaches COLL_THRESH. This is mid-frame; no waiting for the tick.
  - CRASH -> OVER when crash_frames counter reaches CRASH_FRAMES. The counter starts at 0 on entry and increments per tick.
  - OVER -> IDLE on start_pulse.
  - start_pulse in PLAY or CRASH is ignored.
- freeze:
  - 0 only in PLAY.
  - Changes in the cycle after the state changes.
- Score:
  - In PLAY, a frame counter increments per tick.
  - At SCORE_DIV-1 the frame counter wraps to 0 and score increments.
  - Score saturates at all-ones and does not wrap.
  - Score holds its value in CRASH and OVER.
- Pixel mux (registered, 1-cycle latency):
  - !video_on -> 0.
  - IDLE -> background_in.
  - PLAY -> player_car_in if nonzero, else moving_cars_in if nonzero, else background_in.
  - CRASH -> same as PLAY, except player car is suppressed while crash_frames[3]=1. This gives an 8-frame blink.
  - OVER -> game_over_in if nonzero, else background_in.
- Alignment:
  - Pixel inputs are sampled in the same cycle as each other.
  - Latency matching of the upstream stages is their responsibility.
- Simultaneous events:
  - Frame tick and coll_cnt reaching threshold in the same cycle: the crash wins. The clear applies, and the state still goes to CRASH.
  - reset at any time overrides everything. Returns to reset values on the next edge.

Optional Feature:
- HIGH_SCORE_EN
  - Defined: adds output port high_score [SCORE_W].
    - Reset to 0.
    - On the OVER-entry cycle, loads score if score > high_score.
    - Survives OVER->IDLE; cleared only by reset.
  - Undefined: no port and no register. Behaviour is otherwise identical.

Decomposition:
- Shared package (game_pkg):
  - State encodings ST_IDLE/ST_PLAY/ST_CRASH/ST_OVER.
  - Colour constants BLACK=12'h000, WHITE=12'hFFF.
  - Screen size constants 640/480.
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse. Reused for other buttons.

Test Plan:
- Reset, then one start_btn press held 1 ms -> exactly one start_pulse; state IDLE->PLAY; freeze=0; score=0.
- In PLAY, 90 frame ticks with no collisions -> score=3; state stays PLAY.
- 3 collision pixels in frame N, then 3 in frame N+1 -> no crash. 4 in one frame -> CRASH on the cycle after the 4th; freeze=1.
- In CRASH, count ticks -> OVER after exactly 60 ticks. Player pixel suppressed during crash_frames 8-15.
- In OVER, game_over_in=12'hF00 -> pixel_out=12'hF00 one cycle later. game_over_in=0 with background_in=12'h0A0 -> 12'h0A0. video_on=0 -> 0.
- Mid-PLAY synchronous reset with score=5 -> next edge state IDLE, score=0, pixel_out=0. With HIGH_SCORE_EN defined, high_score=0 after reset.
